// File: rtl/threshold_pkg.sv
// Shared definitions for the threshold_pixel actor.
//   state_e           : actor FSM states
//   PIX_W / CNT_W     : pixel and frame-counter widths
//   *_DEF             : default frame size and output levels
package threshold_pkg;

  localparam int unsigned PIX_W = 16;
  localparam int unsigned CNT_W = 32;

  localparam logic [CNT_W-1:0] FRAME_PIXELS_DEF = 32'h40000;
  localparam logic [PIX_W-1:0] OUT_HI_DEF       = 16'hFF;
  localparam logic [PIX_W-1:0] OUT_LO_DEF       = 16'h0;

  typedef enum logic [1:0] {
    StWaitMax,
    StCalc,
    StStream
  } state_e;

endpackage

// File: rtl/threshold_scale.sv
// Registered threshold scaler: thr_o <= trunc16((max_i * ThreshNum) >>> ThreshShift).
// The product is formed as a signed 24-bit value; ThreshNum is unsigned.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (clears thr_o)
//   en_i   : load a new threshold on this edge
//   max_i  : signed frame maximum
//   thr_o  : signed threshold, valid one cycle after en_i
module threshold_scale
  import threshold_pkg::*;
#(
  parameter logic [7:0]  ThreshNum   = 8'd128,
  parameter int unsigned ThreshShift = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [PIX_W-1:0] max_i,
  output logic [PIX_W-1:0] thr_o
);

  logic signed [24:0] max_ext;
  logic signed [24:0] num_ext;
  logic signed [24:0] prod_full;
  logic signed [23:0] prod;
  logic signed [23:0] prod_shr;
  logic [PIX_W-1:0]   thr_d, thr_q;

  always_comb begin
    max_ext   = 25'($signed(max_i));
    num_ext   = $signed({17'b0, ThreshNum});
    prod_full = max_ext * num_ext;
    // 16b signed x 8b unsigned always fits in 24 signed bits.
    prod      = prod_full[23:0];
    prod_shr  = prod >>> ThreshShift;
    thr_d     = en_i ? prod_shr[PIX_W-1:0] : thr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      thr_q <= '0;
    end else begin
      thr_q <= thr_d;
    end
  end

  assign thr_o = thr_q;

endmodule

// File: rtl/threshold_pixel.sv
// Binary-threshold actor. Per frame: take one max token, derive a threshold as
// max*THRESH_NUM >>> THRESH_SHIFT, then classify FRAME_PIXELS pixels against it,
// emitting OUT_HI (pixel > threshold) or OUT_LO.
//   CLK, RESET                 : clock, synchronous active-high reset
//   Max_DATA/SEND/COUNT, ACK   : max token input, ACK pulses on consume
//   Pix_DATA/SEND/COUNT, ACK   : pixel input, ACK pulses on consume
//   Out1_DATA/SEND/COUNT       : classified pixel output; Out1_RDY gates firing
//   loadMax_go/done            : max-load firing strobe and registered copy
//   classify_go/done           : classify firing strobe and registered copy
module threshold_pixel
  import threshold_pkg::*;
#(
  parameter logic [CNT_W-1:0] FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter logic [7:0]       THRESH_NUM   = 8'd128,
  parameter int unsigned      THRESH_SHIFT = 8,
  parameter logic [PIX_W-1:0] OUT_HI       = OUT_HI_DEF,
  parameter logic [PIX_W-1:0] OUT_LO       = OUT_LO_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [PIX_W-1:0] Max_DATA,
  input  logic             Max_SEND,
  input  logic [15:0]      Max_COUNT,
  output logic             Max_ACK,
  input  logic [PIX_W-1:0] Pix_DATA,
  input  logic             Pix_SEND,
  input  logic [15:0]      Pix_COUNT,
  output logic             Pix_ACK,
  output logic [PIX_W-1:0] Out1_DATA,
  output logic             Out1_SEND,
  input  logic             Out1_RDY,
  input  logic             Out1_ACK,
  output logic [15:0]      Out1_COUNT,
  output logic             loadMax_go,
  output logic             loadMax_done,
  output logic             classify_go,
  output logic             classify_done
);

  state_e           state_d, state_q;
  logic [PIX_W-1:0] max_d, max_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             load_done_q, classify_done_q;
  logic [PIX_W-1:0] thr;
  logic             load_fire, classify_fire, scale_en;
  logic             live;

  logic unused_inputs;
  assign unused_inputs = ^{Max_COUNT, Pix_COUNT, Out1_ACK};

  threshold_scale #(
    .ThreshNum   (THRESH_NUM),
    .ThreshShift (THRESH_SHIFT)
  ) u_scale (
    .clk_i (CLK),
    .rst_i (RESET),
    .en_i  (scale_en),
    .max_i (max_q),
    .thr_o (thr)
  );

  always_comb begin
    state_d       = state_q;
    max_d         = max_q;
    cnt_d         = cnt_q;
    load_fire     = 1'b0;
    classify_fire = 1'b0;
    scale_en      = 1'b0;
    unique case (state_q)
      StWaitMax: begin
        if (Max_SEND) begin
          load_fire = 1'b1;
          max_d     = Max_DATA;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        scale_en = 1'b1;
        cnt_d    = '0;
        state_d  = StStream;
      end
      StStream: begin
        if (Pix_SEND && Out1_RDY) begin
          classify_fire = 1'b1;
          cnt_d         = cnt_q + CNT_W'(1);
          if (cnt_q == FRAME_PIXELS - CNT_W'(1)) begin
            state_d = StWaitMax;
          end
        end
      end
      default: state_d = StWaitMax;
    endcase
  end

  // Registers still hold pre-reset values during the reset cycle; mask outputs.
  assign live          = ~RESET;
  assign Max_ACK       = load_fire & live;
  assign loadMax_go    = load_fire & live;
  assign Pix_ACK       = classify_fire & live;
  assign Out1_SEND     = classify_fire & live;
  assign classify_go   = classify_fire & live;
  assign Out1_COUNT    = {15'b0, classify_fire & live};
  assign Out1_DATA     = (classify_fire && live) ?
                         (($signed(Pix_DATA) > $signed(thr)) ? OUT_HI : OUT_LO) : '0;
  assign loadMax_done  = load_done_q & live;
  assign classify_done = classify_done_q & live;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= StWaitMax;
      max_q           <= '0;
      cnt_q           <= '0;
      load_done_q     <= 1'b0;
      classify_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      max_q           <= max_d;
      cnt_q           <= cnt_d;
      load_done_q     <= load_fire;
      classify_done_q <= classify_fire;
    end
  end

endmodule

// File: tb/tb_threshold_pixel.sv
module tb_threshold_pixel;

  logic        clk = 1'b0;
  logic        RESET;
  logic [15:0] Max_DATA, Pix_DATA, Out1_DATA, Out1_COUNT;
  logic        Max_SEND, Pix_SEND, Out1_RDY;
  logic        Max_ACK, Pix_ACK, Out1_SEND;
  logic        loadMax_go, loadMax_done, classify_go, classify_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  threshold_pixel #(
    .FRAME_PIXELS (32'd4),
    .THRESH_NUM   (8'd128),
    .THRESH_SHIFT (8),
    .OUT_HI       (16'hFF),
    .OUT_LO       (16'h0)
  ) dut (
    .CLK           (clk),
    .RESET         (RESET),
    .Max_DATA      (Max_DATA),
    .Max_SEND      (Max_SEND),
    .Max_COUNT     (16'h1),
    .Max_ACK       (Max_ACK),
    .Pix_DATA      (Pix_DATA),
    .Pix_SEND      (Pix_SEND),
    .Pix_COUNT     (16'h1),
    .Pix_ACK       (Pix_ACK),
    .Out1_DATA     (Out1_DATA),
    .Out1_SEND     (Out1_SEND),
    .Out1_RDY      (Out1_RDY),
    .Out1_ACK      (1'b0),
    .Out1_COUNT    (Out1_COUNT),
    .loadMax_go    (loadMax_go),
    .loadMax_done  (loadMax_done),
    .classify_go   (classify_go),
    .classify_done (classify_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs just after a rising edge; outputs are then sampled at the falling edge.
  task automatic drive(input logic rst, input logic msend, input logic [15:0] mdata,
                       input logic psend, input logic [15:0] pdata, input logic rdy);
    @(posedge clk);
    #1;
    RESET    = rst;
    Max_SEND = msend;
    Max_DATA = mdata;
    Pix_SEND = psend;
    Pix_DATA = pdata;
    Out1_RDY = rdy;
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic fire, input logic [15:0] data);
    check({tag, ".pix_ack"}, 32'(Pix_ACK), 32'(fire));
    check({tag, ".send"}, 32'(Out1_SEND), 32'(fire));
    check({tag, ".data"}, 32'(Out1_DATA), 32'(data));
    check({tag, ".count"}, 32'(Out1_COUNT), 32'(fire));
    check({tag, ".cls_go"}, 32'(classify_go), 32'(fire));
  endtask

  task automatic pix(input string tag, input logic [15:0] pdata, input logic rdy,
                     input logic fire, input logic [15:0] data);
    drive(1'b0, 1'b0, 16'h0, 1'b1, pdata, rdy);
    check_out(tag, fire, data);
  endtask

  // Max accept cycle then CALC cycle, with pixels pending throughout.
  task automatic start_frame(input string tag, input logic [15:0] mdata);
    drive(1'b0, 1'b1, mdata, 1'b1, 16'h7FFF, 1'b1);
    check({tag, ".max_ack"}, 32'(Max_ACK), 32'd1);
    check({tag, ".load_go"}, 32'(loadMax_go), 32'd1);
    check({tag, ".pix_ack_wait"}, 32'(Pix_ACK), 32'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h7FFF, 1'b1);
    check({tag, ".load_done"}, 32'(loadMax_done), 32'd1);
    check({tag, ".max_ack_calc"}, 32'(Max_ACK), 32'd0);
    check_out({tag, ".calc"}, 1'b0, 16'h0);
  endtask

  initial begin
    int n_out;
    int n_ack;
    logic [15:0] pv [4];
    logic [15:0] ev [4];

    RESET = 1'b1; Max_SEND = 1'b0; Max_DATA = '0;
    Pix_SEND = 1'b0; Pix_DATA = '0; Out1_RDY = 1'b0;

    // Reset with inputs active: every output stays zero.
    drive(1'b1, 1'b1, 16'd200, 1'b1, 16'd300, 1'b1);
    check("rst.max_ack", 32'(Max_ACK), 32'd0);
    check_out("rst", 1'b0, 16'h0);
    check("rst.done", 32'({loadMax_done, classify_done, loadMax_go}), 32'd0);
    drive(1'b1, 1'b0, 16'd0, 1'b1, 16'd300, 1'b1);
    check_out("rst2", 1'b0, 16'h0);

    // Pixels pending before any max token: nothing fires.
    for (int i = 0; i < 3; i++) pix("nomax", 16'd300, 1'b1, 1'b0, 16'h0);

    // Frame 1: max=200 -> thr=100; first pixel ACK two cycles after Max_ACK.
    start_frame("f1", 16'd200);
    pix("f1.p0", 16'd50, 1'b1, 1'b1, 16'h00);
    check("f1.cls_done", 32'(classify_done), 32'd0);
    pix("f1.p1", 16'd100, 1'b1, 1'b1, 16'h00);
    check("f1.cls_done1", 32'(classify_done), 32'd1);
    pix("f1.p2", 16'd101, 1'b1, 1'b1, 16'hFF);
    pix("f1.p3", 16'd255, 1'b1, 1'b1, 16'hFF);
    pix("f1.end", 16'd255, 1'b1, 1'b0, 16'h0);

    // Frame 2: max=-200 -> thr=-100, Out1_RDY toggling.
    start_frame("f2", 16'hFF38);
    pv[0] = 16'hFF9D; ev[0] = 16'hFF;  // -99
    pv[1] = 16'hFF9C; ev[1] = 16'h00;  // -100
    pv[2] = 16'hFF9B; ev[2] = 16'h00;  // -101
    pv[3] = 16'h0000; ev[3] = 16'hFF;
    n_out = 0;
    for (int i = 0; i < 4; i++) begin
      pix("f2.rdy0", pv[i], 1'b0, 1'b0, 16'h0);
      n_out += int'(Out1_SEND);
      pix("f2.rdy1", pv[i], 1'b1, 1'b1, ev[i]);
      n_out += int'(Out1_SEND);
    end
    check("f2.n_out", 32'(n_out), 32'd4);
    pix("f2.end", 16'd0, 1'b1, 1'b0, 16'h0);

    // Reset mid-frame aborts it; new frame max=20 -> thr=10.
    start_frame("f3", 16'd200);
    pix("f3.p0", 16'd300, 1'b1, 1'b1, 16'hFF);
    pix("f3.p1", 16'd0, 1'b1, 1'b1, 16'h00);
    drive(1'b1, 1'b0, 16'd0, 1'b1, 16'd300, 1'b1);
    check_out("f3.rst", 1'b0, 16'h0);
    check("f3.rst_done", 32'(classify_done), 32'd0);
    pix("f3.post", 16'd300, 1'b1, 1'b0, 16'h0);
    check("f3.post_done", 32'(classify_done), 32'd0);
    start_frame("f4", 16'd20);
    pix("f4.p0", 16'd11, 1'b1, 1'b1, 16'hFF);
    pix("f4.p1", 16'd10, 1'b1, 1'b1, 16'h00);
    pix("f4.p2", 16'd9, 1'b1, 1'b1, 16'h00);
    pix("f4.p3", 16'hFFFB, 1'b1, 1'b1, 16'h00);

    // Max_SEND held high: one Max_ACK per 6-cycle frame (WAIT, CALC, 4 pixels).
    n_ack = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 16'd200, 1'b1, 16'd150, 1'b1);
      check("hold.max_ack", 32'(Max_ACK), 32'((i % 6) == 0));
      check("hold.pix_ack", 32'(Pix_ACK), 32'((i % 6) >= 2));
      n_ack += int'(Max_ACK);
    end
    check("hold.n_ack", 32'(n_ack), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
